// File: rtl/multi_port_cam_regfile_if.sv
// Bus bundle for multi_port_cam_regfile: write, invalidate, read and CAM ports.
// master drives requests and observes results; slave is the register file.
interface multi_port_cam_regfile_if #(
    parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 8,
    parameter int unsigned NUM_ENTRY                  = 4,
    parameter int unsigned NUM_READ_PORT              = 2
);
    localparam int unsigned INDEX_WIDTH = $clog2(NUM_ENTRY);

    logic                                            write_en_in;
    logic [NUM_ENTRY-1:0]                            write_entry_addr_decoded_in;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]           write_entry_in;
    logic                                            invalidate_en_in;
    logic [NUM_ENTRY-1:0]                            invalidate_addr_decoded_in;
    logic [NUM_READ_PORT-1:0]                        read_en_in;
    logic [NUM_READ_PORT*NUM_ENTRY-1:0]              read_entry_addr_decoded_in;
    logic [NUM_READ_PORT*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] read_entry_out;
    logic                                            cam_en_in;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]           cam_entry_in;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]           cam_mask_in;
    logic [NUM_ENTRY-1:0]                            cam_result_decoded_out;
    logic                                            cam_hit_out;
    logic [INDEX_WIDTH-1:0]                          cam_first_index_out;
    logic [NUM_ENTRY-1:0]                            valid_out;

    modport master (
        output write_en_in, write_entry_addr_decoded_in, write_entry_in,
        output invalidate_en_in, invalidate_addr_decoded_in,
        output read_en_in, read_entry_addr_decoded_in,
        output cam_en_in, cam_entry_in, cam_mask_in,
        input  read_entry_out, cam_result_decoded_out, cam_hit_out, cam_first_index_out,
        input  valid_out
    );

    modport slave (
        input  write_en_in, write_entry_addr_decoded_in, write_entry_in,
        input  invalidate_en_in, invalidate_addr_decoded_in,
        input  read_en_in, read_entry_addr_decoded_in,
        input  cam_en_in, cam_entry_in, cam_mask_in,
        output read_entry_out, cam_result_decoded_out, cam_hit_out, cam_first_index_out,
        output valid_out
    );
endinterface

// File: rtl/multi_port_cam_regfile.sv
// Register file with multi-hot write, independent registered read ports and a masked CAM
// lookup that reports a hit vector, hit flag and lowest matching index.
module multi_port_cam_regfile #(
    parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 8,
    parameter int unsigned NUM_ENTRY                  = 4,
    parameter int unsigned NUM_READ_PORT              = 2,
    parameter int unsigned WRITE_BYPASS               = 1
) (
    input  logic                    clk_in,
    input  logic                    reset_n_in,
    multi_port_cam_regfile_if.slave bus
);
    localparam int unsigned Width       = SINGLE_ENTRY_WIDTH_IN_BITS;
    localparam int unsigned INDEX_WIDTH = $clog2(NUM_ENTRY);

    logic [NUM_ENTRY-1:0][Width-1:0]     data_q, data_d;
    logic [NUM_ENTRY-1:0]                valid_q, valid_d;
    logic [NUM_READ_PORT-1:0][Width-1:0] read_q, read_d;
    logic [NUM_ENTRY-1:0]                cam_result_q, cam_result_d;
    logic                                cam_hit_q, cam_hit_d;
    logic [INDEX_WIDTH-1:0]              cam_index_q, cam_index_d;
    logic [NUM_ENTRY-1:0]                cam_match;
    logic [INDEX_WIDTH-1:0]              cam_first;

    // Write beats invalidate when both target the same entry.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        for (int i = 0; i < int'(NUM_ENTRY); i++) begin
            if (bus.write_en_in && bus.write_entry_addr_decoded_in[i]) begin
                data_d[i] = bus.write_entry_in;
            end
        end
        if (bus.invalidate_en_in) valid_d = valid_d & ~bus.invalidate_addr_decoded_in;
        if (bus.write_en_in)      valid_d = valid_d | bus.write_entry_addr_decoded_in;
    end

    always_comb begin
        read_d = read_q;
        for (int p = 0; p < int'(NUM_READ_PORT); p++) begin
            if (bus.read_en_in[p]) begin
                read_d[p] = '0;
                for (int i = 0; i < int'(NUM_ENTRY); i++) begin
                    if (bus.read_entry_addr_decoded_in[p*int'(NUM_ENTRY) + i]) begin
                        read_d[p] = read_d[p] | ((WRITE_BYPASS != 0) ? data_d[i] : data_q[i]);
                    end
                end
            end
        end
    end

    // CAM compares against pre-edge state only; same-cycle updates are not visible.
    always_comb begin
        cam_match = '0;
        for (int i = 0; i < int'(NUM_ENTRY); i++) begin
            cam_match[i] = valid_q[i] &
                           (((data_q[i] ^ bus.cam_entry_in) & bus.cam_mask_in) == '0);
        end
        cam_first = '0;
        for (int i = int'(NUM_ENTRY) - 1; i >= 0; i--) begin
            if (cam_match[i]) cam_first = INDEX_WIDTH'(i);
        end
        cam_result_d = bus.cam_en_in ? cam_match : cam_result_q;
        cam_hit_d    = bus.cam_en_in ? (|cam_match) : cam_hit_q;
        cam_index_d  = bus.cam_en_in ? cam_first : cam_index_q;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            data_q       <= '0;
            valid_q      <= '0;
            read_q       <= '0;
            cam_result_q <= '0;
            cam_hit_q    <= 1'b0;
            cam_index_q  <= '0;
        end else begin
            data_q       <= data_d;
            valid_q      <= valid_d;
            read_q       <= read_d;
            cam_result_q <= cam_result_d;
            cam_hit_q    <= cam_hit_d;
            cam_index_q  <= cam_index_d;
        end
    end

    assign bus.read_entry_out         = read_q;
    assign bus.cam_result_decoded_out = cam_result_q;
    assign bus.cam_hit_out            = cam_hit_q;
    assign bus.cam_first_index_out    = cam_index_q;
    assign bus.valid_out              = valid_q;
endmodule

// File: tb/tb_multi_port_cam_regfile.sv
// Randomised and directed bench for multi_port_cam_regfile against an array-based model;
// a second instance without write bypass shares the same stimulus.
module tb_multi_port_cam_regfile;
    logic clk_in     = 1'b0;
    logic reset_n_in = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk_in = ~clk_in;

    multi_port_cam_regfile_if #(.SINGLE_ENTRY_WIDTH_IN_BITS(8), .NUM_ENTRY(4), .NUM_READ_PORT(2))
        bus ();
    multi_port_cam_regfile_if #(.SINGLE_ENTRY_WIDTH_IN_BITS(8), .NUM_ENTRY(4), .NUM_READ_PORT(2))
        bus_nb ();

    assign bus_nb.write_en_in                 = bus.write_en_in;
    assign bus_nb.write_entry_addr_decoded_in = bus.write_entry_addr_decoded_in;
    assign bus_nb.write_entry_in              = bus.write_entry_in;
    assign bus_nb.invalidate_en_in            = bus.invalidate_en_in;
    assign bus_nb.invalidate_addr_decoded_in  = bus.invalidate_addr_decoded_in;
    assign bus_nb.read_en_in                  = bus.read_en_in;
    assign bus_nb.read_entry_addr_decoded_in  = bus.read_entry_addr_decoded_in;
    assign bus_nb.cam_en_in                   = bus.cam_en_in;
    assign bus_nb.cam_entry_in                = bus.cam_entry_in;
    assign bus_nb.cam_mask_in                 = bus.cam_mask_in;

    multi_port_cam_regfile #(
        .SINGLE_ENTRY_WIDTH_IN_BITS(8), .NUM_ENTRY(4), .NUM_READ_PORT(2), .WRITE_BYPASS(1)
    ) u_dut (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .bus        (bus)
    );

    multi_port_cam_regfile #(
        .SINGLE_ENTRY_WIDTH_IN_BITS(8), .NUM_ENTRY(4), .NUM_READ_PORT(2), .WRITE_BYPASS(0)
    ) u_dut_nb (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .bus        (bus_nb)
    );

    // Reference model state.
    logic [7:0] m_data [4];
    logic [3:0] m_valid;
    logic [7:0] m_rd [2];
    logic [7:0] m_rd_nb [2];
    logic [3:0] m_cam_vec;
    logic       m_hit;
    logic [1:0] m_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_data[i] = 8'h00;
        for (int p = 0; p < 2; p++) begin
            m_rd[p]    = 8'h00;
            m_rd_nb[p] = 8'h00;
        end
        m_valid   = 4'b0;
        m_cam_vec = 4'b0;
        m_hit     = 1'b0;
        m_idx     = 2'd0;
    endtask

    task automatic clear_inputs();
        bus.write_en_in                 = 1'b0;
        bus.write_entry_addr_decoded_in = '0;
        bus.write_entry_in              = '0;
        bus.invalidate_en_in            = 1'b0;
        bus.invalidate_addr_decoded_in  = '0;
        bus.read_en_in                  = '0;
        bus.read_entry_addr_decoded_in  = '0;
        bus.cam_en_in                   = 1'b0;
        bus.cam_entry_in                = '0;
        bus.cam_mask_in                 = '0;
    endtask

    task automatic compare_all();
        for (int p = 0; p < 2; p++) begin
            check($sformatf("rd%0d", p), 32'(bus.read_entry_out[p*8 +: 8]), 32'(m_rd[p]));
            check($sformatf("rd_nb%0d", p), 32'(bus_nb.read_entry_out[p*8 +: 8]),
                  32'(m_rd_nb[p]));
        end
        check("cam_vec", 32'(bus.cam_result_decoded_out), 32'(m_cam_vec));
        check("cam_hit", 32'(bus.cam_hit_out), 32'(m_hit));
        check("cam_idx", 32'(bus.cam_first_index_out), 32'(m_idx));
        check("valid", 32'(bus.valid_out), 32'(m_valid));
        check("valid_nb", 32'(bus_nb.valid_out), 32'(m_valid));
    endtask

    // Apply current inputs at the next edge, advance the model, then compare.
    task automatic cycle();
        logic [7:0] n_data [4];
        logic [3:0] n_valid;
        logic [7:0] n_rd [2];
        logic [7:0] n_rd_nb [2];
        logic [3:0] n_vec;
        logic       n_hit;
        logic [1:0] n_idx;
        bit         found;
        for (int i = 0; i < 4; i++) begin
            n_data[i] = (bus.write_en_in && bus.write_entry_addr_decoded_in[i])
                        ? bus.write_entry_in : m_data[i];
        end
        for (int i = 0; i < 4; i++) begin
            n_valid[i] = m_valid[i];
            if (bus.invalidate_en_in && bus.invalidate_addr_decoded_in[i]) n_valid[i] = 1'b0;
            if (bus.write_en_in && bus.write_entry_addr_decoded_in[i])     n_valid[i] = 1'b1;
        end
        for (int p = 0; p < 2; p++) begin
            n_rd[p]    = m_rd[p];
            n_rd_nb[p] = m_rd_nb[p];
            if (bus.read_en_in[p]) begin
                n_rd[p]    = 8'h00;
                n_rd_nb[p] = 8'h00;
                for (int i = 0; i < 4; i++) begin
                    if (bus.read_entry_addr_decoded_in[p*4 + i]) begin
                        n_rd[p]    = n_rd[p] | n_data[i];
                        n_rd_nb[p] = n_rd_nb[p] | m_data[i];
                    end
                end
            end
        end
        n_vec = m_cam_vec;
        n_hit = m_hit;
        n_idx = m_idx;
        if (bus.cam_en_in) begin
            found = 1'b0;
            n_idx = 2'd0;
            for (int i = 0; i < 4; i++) begin
                n_vec[i] = m_valid[i] &&
                           ((m_data[i] & bus.cam_mask_in) == (bus.cam_entry_in & bus.cam_mask_in));
                if (n_vec[i] && !found) begin
                    found = 1'b1;
                    n_idx = 2'(i);
                end
            end
            n_hit = found;
        end
        @(posedge clk_in);
        for (int i = 0; i < 4; i++) m_data[i] = n_data[i];
        for (int p = 0; p < 2; p++) begin
            m_rd[p]    = n_rd[p];
            m_rd_nb[p] = n_rd_nb[p];
        end
        m_valid   = n_valid;
        m_cam_vec = n_vec;
        m_hit     = n_hit;
        m_idx     = n_idx;
        #1;
        compare_all();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        #1;
        compare_all();
        @(negedge clk_in);
        reset_n_in = 1'b1;

        // Invalid entries never match even though their data is zero.
        bus.cam_en_in = 1'b1; bus.cam_entry_in = 8'h00; bus.cam_mask_in = 8'hFF;
        cycle();
        check("t3_vec", 32'(bus.cam_result_decoded_out), 32'h0);
        check("t3_hit", 32'(bus.cam_hit_out), 32'h0);
        clear_inputs();

        bus.write_en_in = 1'b1; bus.write_entry_addr_decoded_in = 4'b0001;
        bus.write_entry_in = 8'hF0;
        cycle();
        clear_inputs();
        bus.read_en_in = 2'b01; bus.read_entry_addr_decoded_in = 8'b0000_0001;
        cycle();
        check("t1_rd0", 32'(bus.read_entry_out[7:0]), 32'hF0);
        clear_inputs();

        bus.write_en_in = 1'b1; bus.write_entry_addr_decoded_in = 4'b1010;
        bus.write_entry_in = 8'h0F;
        bus.read_en_in = 2'b10; bus.read_entry_addr_decoded_in = 8'b0010_0000;
        cycle();
        check("t2_bypass", 32'(bus.read_entry_out[15:8]), 32'h0F);
        check("t2_nobypass", 32'(bus_nb.read_entry_out[15:8]), 32'h00);
        clear_inputs();

        bus.write_en_in = 1'b1; bus.write_entry_addr_decoded_in = 4'b1111;
        bus.write_entry_in = 8'hF0;
        cycle();
        bus.write_entry_addr_decoded_in = 4'b1010; bus.write_entry_in = 8'h0F;
        cycle();
        clear_inputs();
        bus.cam_en_in = 1'b1; bus.cam_entry_in = 8'hF0; bus.cam_mask_in = 8'hFF;
        cycle();
        check("t4a_vec", 32'(bus.cam_result_decoded_out), 32'b0101);
        check("t4a_idx", 32'(bus.cam_first_index_out), 32'd0);
        bus.cam_entry_in = 8'h0F;
        cycle();
        check("t4b_vec", 32'(bus.cam_result_decoded_out), 32'b1010);
        check("t4b_idx", 32'(bus.cam_first_index_out), 32'd1);
        clear_inputs();

        bus.invalidate_en_in = 1'b1; bus.invalidate_addr_decoded_in = 4'b0001;
        cycle();
        clear_inputs();
        bus.cam_en_in = 1'b1; bus.cam_entry_in = 8'hF0; bus.cam_mask_in = 8'hFF;
        cycle();
        check("t5_vec", 32'(bus.cam_result_decoded_out), 32'b0100);
        check("t5_idx", 32'(bus.cam_first_index_out), 32'd2);
        clear_inputs();
        bus.write_en_in = 1'b1; bus.write_entry_addr_decoded_in = 4'b1000;
        bus.write_entry_in = 8'h5A;
        bus.invalidate_en_in = 1'b1; bus.invalidate_addr_decoded_in = 4'b1000;
        cycle();
        check("t5_wins", 32'(bus.valid_out[3]), 32'h1);
        clear_inputs();

        bus.cam_en_in = 1'b1; bus.cam_entry_in = 8'h00; bus.cam_mask_in = 8'h00;
        cycle();
        check("t6_vec", 32'(bus.cam_result_decoded_out), 32'b1110);
        check("t6_idx", 32'(bus.cam_first_index_out), 32'd1);

        // Asynchronous reset between edges while a lookup is pending.
        bus.read_en_in = 2'b11; bus.read_entry_addr_decoded_in = 8'b0100_0010;
        #2;
        reset_n_in = 1'b0;
        #1;
        check("arst_rd", 32'(bus.read_entry_out), 32'h0);
        check("arst_vec", 32'(bus.cam_result_decoded_out), 32'h0);
        check("arst_hit", 32'(bus.cam_hit_out), 32'h0);
        check("arst_valid", 32'(bus.valid_out), 32'h0);
        model_reset();
        compare_all();
        clear_inputs();
        @(posedge clk_in);
        @(negedge clk_in);
        reset_n_in = 1'b1;

        for (int n = 0; n < 400; n++) begin
            bus.write_en_in                 = ($urandom_range(0, 1) == 1);
            bus.write_entry_addr_decoded_in = 4'($urandom_range(0, 15));
            bus.write_entry_in              = ($urandom_range(0, 3) == 0)
                                              ? m_data[$urandom_range(0, 3)]
                                              : 8'($urandom_range(0, 255));
            bus.invalidate_en_in            = ($urandom_range(0, 3) == 0);
            bus.invalidate_addr_decoded_in  = 4'($urandom_range(0, 15));
            bus.read_en_in                  = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                bus.read_entry_addr_decoded_in[p*4 +: 4] =
                    ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'(1 << $urandom_range(0, 3));
            end
            bus.cam_en_in    = ($urandom_range(0, 3) != 0);
            bus.cam_entry_in = ($urandom_range(0, 1) == 1) ? m_data[$urandom_range(0, 3)]
                                                           : 8'($urandom_range(0, 255));
            bus.cam_mask_in  = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom_range(0, 255));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
